// File: rtl/gray_code_pipe.sv
// Two-stage streaming Gray<->binary converter with a Gray-adjacency monitor on mode-0 words.
// Latency 2 cycles, 1 word/cycle; a stalled output holds every stage via a shared enable.
module gray_code_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic             en;
  logic             accept;
  logic             s1_valid;
  logic             s1_mode;
  logic             s1_err;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] hist_data;
  logic             hist_valid;
  logic [WIDTH-1:0] diff;
  logic             seq_err;
  logic [WIDTH-1:0] conv;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // Adjacent Gray codes differ in exactly one bit: diff is a nonzero power of two.
  assign diff    = in_data ^ hist_data;
  assign seq_err = hist_valid & ~in_mode &
                   ((diff == '0) | ((diff & (diff - 1'b1)) != '0));

  always_comb begin
    conv = '0;
    if (s1_mode) begin
      conv = s1_data ^ (s1_data >> 1);
    end else begin
      conv[WIDTH-1] = s1_data[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        conv[i] = conv[i+1] ^ s1_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_mode    <= 1'b0;
      s1_err     <= 1'b0;
      s1_data    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      err_count  <= '0;
      hist_data  <= '0;
      hist_valid <= 1'b0;
    end else begin
      if (en) begin
        s1_valid  <= accept;
        out_valid <= s1_valid;
        if (accept) begin
          s1_mode <= in_mode;
          s1_data <= in_data;
          s1_err  <= seq_err;
        end
        if (s1_valid) begin
          out_data <= conv;
          out_err  <= s1_err;
          if (s1_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
          end
        end
      end
      // Binary words break the Gray sequence, so the next Gray word starts fresh.
      if (accept) begin
        if (!in_mode) begin
          hist_data  <= in_data;
          hist_valid <= 1'b1;
        end else begin
          hist_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_code_pipe.sv
// Scoreboard bench for gray_code_pipe: directed scenarios then randomized traffic with backpressure.
module tb_gray_code_pipe;
  localparam int W  = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  gray_code_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [W-1:0] m_hist = '0;
  bit           m_hvld = 0;
  int           m_cnt = 0;
  int           bp_cycles = 0;
  bit           rand_rdy = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Binary bit i of a Gray word is the parity of all Gray bits at or above i.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic model_accept(input bit m, input logic [W-1:0] d);
    exp_t e;
    if (!m) begin
      e.data = g2b(d);
      e.err  = m_hvld && ($countones(d ^ m_hist) != 1);
      m_hist = d;
      m_hvld = 1;
    end else begin
      e.data = d ^ (d >> 1);
      e.err  = 1'b0;
      m_hvld = 0;
    end
    if (e.err && m_cnt < CNT_MAX) m_cnt++;
    e.cnt = m_cnt[CW-1:0];
    sbq.push_back(e);
  endtask

  // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
  task automatic send(input bit m, input logic [W-1:0] d);
    int tries = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(m, d);
        break;
      end
      tries++;
      if (tries > 50) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        break;
      end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    sbq.delete();
    m_hvld = 0;
    m_cnt  = 0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #2;
  endtask

  always begin
    @(posedge clk); #1;
    if (bp_cycles > 0) begin
      out_ready = 1'b0;
      if (out_valid) bp_cycles--;
    end else begin
      out_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_err;
  int           idle_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        idle_cnt = 0;
        if (sbq.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_err", 32'(out_err), 32'(e.err));
          check("err_count", 32'(err_count), 32'(e.cnt));
        end
      end else if (sbq.size() > 0 && !out_valid) begin
        idle_cnt++;
        if (idle_cnt > 20) begin
          check("output_timeout", 32'(out_valid), 32'd1);
          idle_cnt = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
    end
  end

  initial begin
    logic [W-1:0] last;
    bit           m;
    logic [W-1:0] d;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;

    send(0, 4'b0110);
    send(1, 4'b1011);
    idle(4);

    send(0, 4'b0000);
    send(0, 4'b0001);
    send(0, 4'b0011);
    send(0, 4'b0010);
    send(0, 4'b0111);
    idle(4);
    check("stream_err_count", 32'(err_count), 32'd1);

    bp_cycles = 4;
    send(0, 4'b0101);
    send(0, 4'b0100);
    send(0, 4'b1100);
    idle(10);
    check("bp_drained", 32'(sbq.size()), 32'd0);

    send(0, 4'b1000);
    send(0, 4'b0000);
    send(0, 4'b0000);
    send(1, 4'b0101);
    send(0, 4'b1111);
    idle(4);
    check("wrap_err_count", 32'(err_count), 32'd2);

    send(0, 4'b0000);
    send(0, 4'b1111);
    send(0, 4'b0000);
    send(0, 4'b1111);
    send(0, 4'b0000);
    idle(4);
    check("sat_err_count", 32'(err_count), 32'd3);

    send(0, 4'b1010);
    send(0, 4'b0101);
    do_reset();
    send(0, 4'b0011);
    idle(4);
    check("post_rst_err_count", 32'(err_count), 32'd0);

    rand_rdy = 1;
    last = '0;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(3) == 0);
      if (!m && $urandom_range(1) == 1) d = last ^ W'(1 << $urandom_range(W - 1));
      else d = W'($urandom);
      if (!m) last = d;
      send(m, d);
      if ($urandom_range(7) == 0) idle($urandom_range(3));
      if (i % 150 == 149) do_reset();
    end

    rand_rdy = 0;
    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    check("final_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_code_pipe.md
Name: gray_code_pipe

Overview:
- Parametrised, pipelined Gray/binary code converter; successor to the fixed 4-bit combinational Gray-to-binary block.
- Generic WIDTH; per-transaction direction select (Gray->binary or binary->Gray); valid/ready streaming handshake with backpressure.
- Gray-sequence monitor flags non-adjacent consecutive Gray codes; used on encoder/counter-crossing datapaths.

Parameters:
- WIDTH, 8, code width in bits (>=2).
- CNT_W, 8, width of the saturating sequence-error counter (>=1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept input this cycle.
- in_mode  in  1  0 = Gray->binary, 1 = binary->Gray; sampled with in_data.
- in_data  in  WIDTH  code word to convert.
- out_valid  out  1  out_data/out_err valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  WIDTH  converted word.
- out_err  out  1  sequence error attached to this word.
- err_count  out  CNT_W  saturating count of flagged words.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst). Fixed.
- Reset values: out_valid=0, out_data=0, out_err=0, err_count=0, both stage valids=0, history-valid flag=0. in_ready=1 in the cycle after reset deasserts.
- Pipeline: stage 1 registers in_data/in_mode; stage 2 (output) registers the converted result.
- Pipeline enable: en = ~out_valid | out_ready. in_ready = en, combinational.
- Stall: when en=0 all stages hold; out_data/out_err stay stable while out_valid=1 and out_ready=0.
- Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
- Latency and throughput: accepted word appears on out_valid exactly 2 cycles later with no stall; 1 word/cycle sustained.
- Bubbles: an empty stage advances as a bubble when en=1; no data invented.
- Mode 0 (Gray->binary): out[WIDTH-1] = g[WIDTH-1]; out[i] = out[i+1] XOR g[i]. Computed between stage 1 and stage 2.
- Mode 1 (binary->Gray): out = b XOR (b >> 1), zero-filled MSB.
- Sequence monitor, mode 0 only:
  - Holds the last accepted mode-0 word plus a history-valid flag.
  - On each accepted mode-0 word with history valid, out_err=1 unless Hamming distance to the previous word is exactly 1. Distance 0 (a repeat) is an error.
  - History then updates to the current word and history-valid sets to 1.
- No check cases:
  - First mode-0 word after reset: out_err=0.
  - Mode-1 words: out_err=0, and they clear history-valid, so the next mode-0 word is unchecked.
- Wrap-around: Gray max (1 followed by WIDTH-1 zeros) -> 0 is distance 1, so no error.
- err_count: increments by 1 when a word with out_err=1 enters stage 2. Saturates at 2^CNT_W-1; no wrap.
- Mid-operation reset: rst overrides handshake. In-flight words are discarded, history cleared, err_count cleared. rst has priority over any simultaneous accept.
- Simultaneous accept and consume: allowed; the pipeline shifts, no loss or duplication.
- No X on outputs after reset regardless of inputs.

Test Plan:
- WIDTH=4, out_ready=1: mode 0, in_data=0110 -> out_data=0100 two cycles later, out_err=0. Then mode 1, in_data=1011 -> out_data=1110.
- WIDTH=4, mode 0 stream 0000,0001,0011,0010,0111 back-to-back:
  - out_data 0000,0001,0010,0011,0101.
  - out_err=1 only on the fifth word (0010->0111 is distance 2); err_count=1.
- Backpressure: three words issued, out_ready=0 for 4 cycles from the first out_valid:
  - out_data held stable; in_ready=0 while out_valid=1.
  - After release, all three words emerge in order with no gaps or duplicates.
- Wrap and repeat, WIDTH=4, mode 0:
  - 1000 -> 0000 gives no error.
  - A following 0000 repeat gives out_err=1.
  - An interleaved mode-1 word, then 1111 in mode 0, gives out_err=0 (history cleared).
- Saturation, CNT_W=2: 5 consecutive non-adjacent mode-0 words -> err_count reaches 3 and stays 3.
- Reset mid-stream: rst=1 for one cycle with 2 words in flight -> next cycle out_valid=0, err_count=0. The next mode-0 word is unchecked (out_err=0).
